// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL field positions, mode codes and FSM state encoding.
package timer_dev_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_word(input logic [3:0] w);
    ctrl_t c;
    c.en   = w[CTRL_EN];
    c.mode = w[CTRL_MODE_HI:CTRL_MODE_LO];
    c.im   = w[CTRL_IM];
    return c;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Countdown timer on the CPU data bus; stores land at the clock edge, RD is combinational.
// No backpressure: every access completes in the cycle it is presented; irq = IM & int_flag.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        irq
);

  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  state_t      state_q, state_d;
  logic        int_flag_q, int_flag_d;

  logic sel;
  logic wr_ctrl;
  logic wr_preset;
  logic expire;
  logic unused_addr_bits;

  assign sel       = (A[31:4] == BASE[31:4]);
  assign wr_ctrl   = sel & WE & (A[3:2] == OFF_CTRL);
  assign wr_preset = sel & WE & (A[3:2] == OFF_PRESET);
  assign unused_addr_bits = ^A[1:0];

  // Counting run ends this edge; a PRESET of 0 expires exactly like a PRESET of 1.
  assign expire = (state_q == ST_CNT) & ctrl_q.en & (count_q <= 32'd1);

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    int_flag_d = int_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q.en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (expire) begin
          count_d    = '0;
          int_flag_d = 1'b1;
          state_d    = ST_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (ctrl_q.mode == MODE_RELOAD) begin
          int_flag_d = 1'b0;
          state_d    = ctrl_q.en ? ST_LOAD : ST_IDLE;
        end else begin
          ctrl_d.en = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_preset) preset_d = WD;

    // CPU store to CTRL overrides the FSM's auto-disable and acknowledges the
    // interrupt, except that an expiry landing on the same edge is not lost.
    if (wr_ctrl) begin
      ctrl_d = ctrl_from_word(WD[3:0]);
      if (!expire) int_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      int_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      int_flag_q <= int_flag_d;
    end
  end

  always_comb begin
    RD = '0;
    if (sel) begin
      case (A[3:2])
        OFF_CTRL:   RD = {28'd0, ctrl_q};
        OFF_PRESET: RD = preset_q;
        OFF_COUNT:  RD = count_q;
        default:    RD = '0;
      endcase
    end
  end

  assign irq = ctrl_q.im & int_flag_q;

endmodule
